qspim_fifo_wr_arb: RTL

- Round-robin burst arbiter that shares the single write port of the qspim sync FIFO (W-bit, full/afull flags) between NREQ requesters, e.g. the AHB write path and the command/address sequencer.
- Grants one requester at a time for a whole burst of programmed length and gates each beat on FIFO full.
- Sits directly in front of the FIFO write side. The FIFO read side is untouched.

---
 rtl/qspim_fifo_wr_arb.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/qspim_fifo_wr_arb.sv
// Round-robin burst arbiter sharing the qspim sync FIFO write port between NREQ requesters.
// The winner owns the port for a whole burst; every beat is gated on the fast FIFO full.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no grant; arbitrate among pending requests from last+1 upward
// BURST | gnt one-hot; write beats until the down-counter reaches zero
module qspim_fifo_wr_arb #(
  parameter int W    = 32,
  parameter int NREQ = 2,
  parameter int BL_W = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*BL_W-1:0] req_len,
  input  logic [NREQ-1:0]      req_vld,
  input  logic [NREQ*W-1:0]    req_data,
  output logic [NREQ-1:0]      req_ack,
  output logic [NREQ-1:0]      gnt,
  output logic                 fifo_wr_en,
  output logic [W-1:0]         fifo_wr_data,
  input  logic                 fifo_full,
  output logic                 busy,
  output logic                 abort_err
);

  localparam int IW = (NREQ > 2) ? 2 : 1;

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [NREQ-1:0] gnt_nxt;
  logic [IW-1:0]   gidx, gidx_nxt;
  logic [IW-1:0]   last, last_nxt;
  logic [BL_W-1:0] cnt, cnt_nxt;
  logic            abort_nxt;

  logic            win_vld;
  logic [IW-1:0]   win_idx;
  logic [BL_W-1:0] win_len;
  logic            g_req, g_vld, beat;
  logic [W-1:0]    g_data;

  // Search downward so the candidate closest to last+1 is written last and wins.
  always_comb begin
    logic [IW-1:0] cand;
    cand    = '0;
    win_vld = 1'b0;
    win_idx = '0;
    win_len = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = IW'((int'(last) + k) % NREQ);
      if (req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == IW'(i)) win_len = req_len[i*BL_W +: BL_W];
    end
  end

  always_comb begin
    g_req  = |(req & gnt);
    g_vld  = |(req_vld & gnt);
    g_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) g_data = req_data[i*W +: W];
    end
  end

  assign beat = (state == BURST) & g_req & g_vld & ~fifo_full & ~flush & reset_n;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      gnt       <= '0;
      gidx      <= '0;
      cnt       <= '0;
      last      <= IW'(NREQ - 1);
      abort_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      gnt       <= gnt_nxt;
      gidx      <= gidx_nxt;
      cnt       <= cnt_nxt;
      last      <= last_nxt;
      abort_err <= abort_nxt;
    end
  end

  // flush wins over a request drop and over a last beat, and restores reset priority.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    gidx_nxt  = gidx;
    cnt_nxt   = cnt;
    last_nxt  = last;
    abort_nxt = 1'b0;
    if (flush) begin
      state_nxt = IDLE;
      gnt_nxt   = '0;
      cnt_nxt   = '0;
      last_nxt  = IW'(NREQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            state_nxt         = BURST;
            gnt_nxt           = '0;
            gnt_nxt[win_idx]  = 1'b1;
            gidx_nxt          = win_idx;
            cnt_nxt           = win_len;
          end
        end
        BURST: begin
          if (!g_req) begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
            last_nxt  = gidx;
            abort_nxt = 1'b1;
          end else if (beat) begin
            if (cnt == '0) begin
              state_nxt = IDLE;
              gnt_nxt   = '0;
              last_nxt  = gidx;
            end else begin
              cnt_nxt = cnt - 1'b1;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    busy         = (state == BURST);
    fifo_wr_en   = beat;
    req_ack      = beat ? gnt : '0;
    fifo_wr_data = g_data;
  end

endmodule
